frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Parametrised audio frame sequencer. It generalises the fixed 240/120 Hz enable generator into a full 4-step/5-step frame counter. It produces the quarter-frame and half-frame enables that clock the envelope, length-counter and sweep units, plus a level frame interrupt. It sits between the system clock domain and the channel blocks, and is configured by a host write strobe (mode register).

## Interface
- CLKRATE, 1_790_000: system clock rate in Hz.
- STEPRATE, 240: sequencer step rate in Hz.
- Derived: PRESCALE = CLKRATE/STEPRATE (integer division, must be ≥ 2); prescaler width PW = $clog2(PRESCALE).
- clk  in  1  system clock (one clock domain).
- rst_n  in  1  reset, asynchronous, active-low.
- wr_strobe  in  1  one-cycle write to the mode register.
- mode_in  in  1  write data: 0 = 4-step, 1 = 5-step.
- inhibit_in  in  1  write data: 1 = frame IRQ inhibited.
- irq_ack  in  1  one-cycle IRQ acknowledge (status read).
- quarter_frame  out  1  registered one-cycle enable.
- half_frame  out  1  registered one-cycle enable.
- frame_irq  out  1  registered level interrupt flag.
- step  out  3  current step index, 0..3 or 0..4.

## Operation
- Reset (rst_n low, asynchronous): prescaler = PRESCALE-1, step = 0, mode = 0, inhibit = 0, quarter_frame = half_frame = frame_irq = 0.
- Prescaler counts down each clk. When it equals 0, the cycle is a tick: reload PRESCALE-1 and advance step. Tick period is exactly PRESCALE clocks.
- Step sequence:
  - mode 0: 0→1→2→3→0.
  - mode 1: 0→1→2→3→4→0.
- Events are decoded from the step value being completed at the tick:
  - mode 0: step 0 Q; step 1 Q+H; step 2 Q; step 3 Q+H, and set frame_irq if inhibit = 0.
  - mode 1: step 0 Q; step 1 Q+H; step 2 Q; step 3 none; step 4 Q+H. Never sets frame_irq.
  - Q means quarter_frame = 1 and H means half_frame = 1, each for one cycle.
- wr_strobe:
  - Latch mode_in and inhibit_in.
  - Set prescaler = PRESCALE-1 and step = 0.
  - If mode_in = 1, emit Q+H on the same registered edge.
  - If inhibit_in = 1, clear frame_irq.
- frame_irq priority, highest first:
  1. Set from step 3.
  2. Clear by irq_ack or by an inhibiting write.
  3. Hold.
- Simultaneous wr_strobe and tick: the write wins. The tick is discarded, so no step-completion event fires and step = 0.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Edge numbering: edge 1 is the first rising clk edge with rst_n high.
- After reset, ticks land on edges PRESCALE, 2·PRESCALE, and so on. quarter_frame/half_frame are high for exactly the one cycle following each such edge.
- A write sampled at edge W restarts timing. Its immediate Q+H (mode 1) is high after edge W. Step-0 completion follows at edge W+PRESCALE.
- irq_ack sampled at edge A makes frame_irq low after edge A, unless a step-3 set occurs at A.
- step updates on the tick edge, in the same cycle as its pulses.
- rst_n assertion clears all state without a clock edge. Deassertion is assumed synchronised upstream.

## Test plan
- Reset run with CLKRATE=2400, STEPRATE=240 (PRESCALE=10), mode 0 → Q at edges 10, 20, 30, 40; H at edges 20, 40; frame_irq rises at edge 40 and holds; step reads 1, 2, 3, 0.
- With frame_irq high, irq_ack at edge 45 → frame_irq low after 45. irq_ack coincident with the step-3 tick at edge 80 → frame_irq stays high.
- wr_strobe at edge W=13 with mode_in=1, inhibit_in=0 → Q+H after edge 13. Then Q at 23, 33, 43, 63 and H at 33, 63; nothing at 53; frame_irq never set.
- frame_irq high, then wr_strobe with mode_in=0, inhibit_in=1 → frame_irq clears after W. Following step-3 ticks produce Q+H but no IRQ.
- wr_strobe (mode 0) exactly on tick edge 20 → no Q/H at 20; step = 0; next Q at edge 30.
- rst_n pulsed low at a mid-step, between clk edges → outputs 0 immediately. After release, first Q arrives PRESCALE edges later.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Audio frame counter. A prescaler divides clk down to STEPRATE; each
//   prescaler expiry ("tick") completes one step of a 4-step (mode 0) or
//   5-step (mode 1) sequence and emits the quarter/half-frame enables for the
//   step that just finished. Mode 0 also raises a level frame interrupt when
//   it completes step 3, unless the IRQ is inhibited.
//
// Parameters
//   CLKRATE   system clock rate in Hz
//   STEPRATE  step rate in Hz; CLKRATE/STEPRATE must be >= 2
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   wr_strobe      one-cycle mode register write
//   mode_in        write data: 0 = 4-step, 1 = 5-step
//   inhibit_in     write data: 1 = frame IRQ inhibited
//   irq_ack        one-cycle IRQ acknowledge
//   quarter_frame  registered one-cycle quarter-frame enable
//   half_frame     registered one-cycle half-frame enable
//   frame_irq      registered level frame interrupt
//   step           current step index (0..3 or 0..4)
module frame_sequencer #(
  parameter int CLKRATE  = 1_790_000,
  parameter int STEPRATE = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_strobe,
  input  logic       mode_in,
  input  logic       inhibit_in,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step
);

  localparam int            PRESCALE = CLKRATE / STEPRATE;
  localparam int            PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] RELOAD   = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          mode;
  logic          inhibit;

  // Step-completion decode, all relative to the step being left at this tick.
  logic       tick;
  logic [2:0] last_step;
  logic [2:0] step_nxt;
  logic       ev_q;
  logic       ev_h;
  logic       irq_set;
  logic       irq_clr;

  always_comb begin
    tick      = (presc == '0);
    last_step = mode ? 3'd4 : 3'd3;
    step_nxt  = (step == last_step) ? 3'd0 : step + 3'd1;
    // Every step emits Q except step 3 of the 5-step sequence.
    ev_q      = !(mode && step == 3'd3);
    // H on step 1 and on the final step of either sequence.
    ev_h      = (step == 3'd1) || (step == last_step);
    // A write on a tick edge discards the tick, so it cannot set the IRQ.
    irq_set   = tick && !wr_strobe && !mode && !inhibit && (step == 3'd3);
    irq_clr   = irq_ack || (wr_strobe && inhibit_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc         <= RELOAD;
      step          <= 3'd0;
      mode          <= 1'b0;
      inhibit       <= 1'b0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_irq     <= 1'b0;
    end else begin
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;

      if (wr_strobe) begin
        // Restart timing; 5-step mode fires Q+H straight away.
        presc         <= RELOAD;
        step          <= 3'd0;
        mode          <= mode_in;
        inhibit       <= inhibit_in;
        quarter_frame <= mode_in;
        half_frame    <= mode_in;
      end else if (tick) begin
        presc         <= RELOAD;
        step          <= step_nxt;
        quarter_frame <= ev_q;
        half_frame    <= ev_h;
      end else begin
        presc <= presc - 1'b1;
      end

      // Set beats clear so an ack coinciding with a step-3 tick is lost.
      if (irq_set)
        frame_irq <= 1'b1;
      else if (irq_clr)
        frame_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer at PRESCALE = 10. The driver applies
// one cycle of stimulus, advances a time-based reference model and queues the
// outputs expected after that edge; a negedge monitor pops and compares.
module tb_frame_sequencer;

  localparam int P = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_strobe = 1'b0;
  logic       mode_in = 1'b0;
  logic       inhibit_in = 1'b0;
  logic       irq_ack = 1'b0;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic [2:0] step;

  frame_sequencer #(.CLKRATE(2400), .STEPRATE(240)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_strobe     (wr_strobe),
    .mode_in       (mode_in),
    .inhibit_in    (inhibit_in),
    .irq_ack       (irq_ack),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .frame_irq     (frame_irq),
    .step          (step)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       q;
    logic       h;
    logic       irq;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: edge count since reset release, edge of the last
  // restart, and the latched mode/inhibit/irq.
  int e, t0;
  bit m_mode, m_inh, m_irq;

  task automatic model_reset();
    e = 0; t0 = 0; m_mode = 0; m_inh = 0; m_irq = 0;
  endtask

  task automatic cyc(input bit wr, input bit mi, input bit ii, input bit ack);
    exp_t x;
    int   ph, n, len, c;
    bit   set;
    wr_strobe = wr; mode_in = mi; inhibit_in = ii; irq_ack = ack;
    @(posedge clk);
    e++;
    x   = '0;
    set = 0;
    if (wr) begin
      t0 = e; m_mode = mi; m_inh = ii;
      x.q = mi; x.h = mi; x.st = 3'd0;
    end else begin
      ph  = e - t0;
      len = m_mode ? 5 : 4;
      n   = ph / P;
      if (ph % P == 0) begin
        c   = (n - 1) % len;
        x.q = !(m_mode && c == 3);
        x.h = (c == 1) || (c == len - 1);
        set = !m_mode && c == 3 && !m_inh;
      end
      x.st = 3'(n % len);
    end
    if (set) m_irq = 1;
    else if (ack || (wr && ii)) m_irq = 0;
    x.irq = m_irq;
    sb.push_back(x);
    #1;
    wr_strobe = 0; mode_in = 0; inhibit_in = 0; irq_ack = 0;
  endtask

  task automatic chk_zero(input string tag);
    vectors++;
    if ({quarter_frame, half_frame, frame_irq, step} !== 6'd0) begin
      miscompares++;
      $display("FAIL %s t=%0t got q%0b h%0b irq%0b st%0d want all zero",
               tag, $time, quarter_frame, half_frame, frame_irq, step);
    end
  endtask

  // Pulse reset between clock edges, check it acts without a clock, then
  // release on a falling edge and restart the model's edge numbering.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_hold");
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && sb.size() > 0) begin
      x = sb.pop_front();
      vectors++;
      if ({quarter_frame, half_frame, frame_irq, step} !== {x.q, x.h, x.irq, x.st}) begin
        miscompares++;
        $display("FAIL out t=%0t edge=%0d got q%0b h%0b irq%0b st%0d want q%0b h%0b irq%0b st%0d",
                 $time, e, quarter_frame, half_frame, frame_irq, step,
                 x.q, x.h, x.irq, x.st);
      end
    end
  end

  initial begin
    model_reset();

    // Mode 0 from reset; ack at 45 clears, ack on the step-3 tick at 80 loses.
    async_reset();
    for (int k = 1; k <= 100; k++) cyc(0, 0, 0, k == 45 || k == 80);

    // 5-step write at edge 13.
    async_reset();
    for (int k = 1; k <= 80; k++) cyc(k == 13, 1, 0, 0);

    // IRQ raised at 40, inhibiting mode-0 write at 46 clears it for good.
    async_reset();
    for (int k = 1; k <= 130; k++) cyc(k == 46, 0, 1, 0);

    // Write coincident with the tick at edge 20.
    async_reset();
    for (int k = 1; k <= 40; k++) cyc(k == 20, 0, 0, 0);

    // Random traffic with periodic mid-run resets.
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      if (i % 1000 == 999) async_reset();
    end

    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
